// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared types and default sizing.
//   rob_entry_t : one ROB slot (valid, completed, store flag, new/old
//                 physical destination, result value).
//   P_*         : default parameter values used by the top level.
package reorder_buffer_pkg;

  localparam int P_DEPTH  = 16;
  localparam int P_DISP_W = 2;
  localparam int P_CMPL_W = 3;
  localparam int P_RET_W  = 2;
  localparam int P_PREG_W = 6;
  localparam int P_DATA_W = 32;

  typedef struct packed {
    logic                v;
    logic                comp;
    logic                is_store;
    logic [P_PREG_W-1:0] preg;
    logic [P_PREG_W-1:0] old_preg;
    logic [P_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_retire_sel.sv
// Retire selector: counts how many consecutive entries starting at head
// are both valid and completed, capped at RET_W.
//   head_i  : current head index
//   valid_i : per-entry valid bits
//   comp_i  : per-entry completed bits
//   cnt_o   : number of entries to retire this cycle (0..RET_W)
module rob_retire_sel #(
  parameter int DEPTH  = 16,
  parameter int RET_W  = 2,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int RCNT_W = $clog2(RET_W+1)
) (
  input  logic [IDX_W-1:0]  head_i,
  input  logic [DEPTH-1:0]  valid_i,
  input  logic [DEPTH-1:0]  comp_i,
  output logic [RCNT_W-1:0] cnt_o
);

  logic [RET_W-1:0][IDX_W-1:0] w_idx;

  always_comb begin
    for (int k = 0; k < RET_W; k++) w_idx[k] = head_i + IDX_W'(k);
  end

  // In-order commit: the first incomplete entry blocks everything behind it.
  always_comb begin
    logic w_stop;
    w_stop = 1'b0;
    cnt_o  = '0;
    for (int k = 0; k < RET_W; k++) begin
      if (!w_stop && valid_i[w_idx[k]] && comp_i[w_idx[k]]) cnt_o = cnt_o + RCNT_W'(1);
      else                                                  w_stop = 1'b1;
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocate, out-of-order complete, in-order retire.
//   clk_i, rst_n_i             : clock, synchronous active-low reset
//   flush_i                    : drop every entry (wins over all other activity)
//   disp_*                     : up to DISP_W allocations per cycle, all-or-nothing
//   disp_tag_o                 : combinational tag per slot (valid slots compacted)
//   cmpl_*                     : CMPL_W result ports addressed by tag
//   fwd_*                      : registered wakeup/forward of each completion
//   ret_*                      : registered in-order retirement, up to RET_W/cycle
//   count_o, empty_o, full_o   : occupancy
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter  int DEPTH  = P_DEPTH,
  parameter  int DISP_W = P_DISP_W,
  parameter  int CMPL_W = P_CMPL_W,
  parameter  int RET_W  = P_RET_W,
  parameter  int PREG_W = P_PREG_W,
  parameter  int DATA_W = P_DATA_W,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             flush_i,
  input  logic [DISP_W-1:0]                disp_valid_i,
  input  logic [DISP_W-1:0]                disp_is_store_i,
  input  logic [DISP_W-1:0][PREG_W-1:0]    disp_preg_i,
  input  logic [DISP_W-1:0][PREG_W-1:0]    disp_old_preg_i,
  output logic                             disp_ready_o,
  output logic [DISP_W-1:0][IDX_W-1:0]     disp_tag_o,
  input  logic [CMPL_W-1:0]                cmpl_valid_i,
  input  logic [CMPL_W-1:0][IDX_W-1:0]     cmpl_tag_i,
  input  logic [CMPL_W-1:0][DATA_W-1:0]    cmpl_data_i,
  output logic [CMPL_W-1:0]                fwd_valid_o,
  output logic [CMPL_W-1:0][PREG_W-1:0]    fwd_preg_o,
  output logic [CMPL_W-1:0][DATA_W-1:0]    fwd_data_o,
  output logic [RET_W-1:0]                 ret_valid_o,
  output logic [RET_W-1:0]                 ret_is_store_o,
  output logic [RET_W-1:0][PREG_W-1:0]     ret_preg_o,
  output logic [RET_W-1:0][PREG_W-1:0]     ret_free_preg_o,
  output logic [RET_W-1:0][DATA_W-1:0]     ret_data_o,
  output logic [IDX_W:0]                   count_o,
  output logic                             empty_o,
  output logic                             full_o
);

  localparam int RCNT_W = $clog2(RET_W+1);

  rob_entry_t                  r_rob [DEPTH];
  logic [IDX_W-1:0]            r_head, r_tail;
  logic [IDX_W:0]              r_count;

  logic [CMPL_W-1:0]             r_fwd_valid;
  logic [CMPL_W-1:0][PREG_W-1:0] r_fwd_preg;
  logic [CMPL_W-1:0][DATA_W-1:0] r_fwd_data;
  logic [RET_W-1:0]              r_ret_valid, r_ret_st;
  logic [RET_W-1:0][PREG_W-1:0]  r_ret_preg, r_ret_free;
  logic [RET_W-1:0][DATA_W-1:0]  r_ret_data;

  logic [IDX_W:0]              w_nalloc, w_nalloc_eff;
  logic                        w_ready;
  logic [DISP_W-1:0][IDX_W-1:0] w_disp_tag;
  logic [DEPTH-1:0]            w_v, w_c;
  logic [RCNT_W-1:0]           w_nret;
  logic [RET_W-1:0][IDX_W-1:0] w_ret_idx;

  // Ready depends only on the registered count, never on same-cycle retires.
  assign w_ready = ((IDX_W+1)'(DEPTH) - r_count) >= (IDX_W+1)'(DISP_W);

  // Compact valid slots: each slot's tag is tail plus the number of valid
  // slots below it.
  always_comb begin
    w_nalloc = '0;
    for (int s = 0; s < DISP_W; s++) begin
      w_disp_tag[s] = r_tail + w_nalloc[IDX_W-1:0];
      if (disp_valid_i[s]) w_nalloc = w_nalloc + (IDX_W+1)'(1);
    end
  end

  assign w_nalloc_eff = w_ready ? w_nalloc : '0;

  always_comb begin
    for (int d = 0; d < DEPTH; d++) begin
      w_v[d] = r_rob[d].v;
      w_c[d] = r_rob[d].comp;
    end
    for (int k = 0; k < RET_W; k++) w_ret_idx[k] = r_head + IDX_W'(k);
  end

  rob_retire_sel #(.DEPTH(DEPTH), .RET_W(RET_W), .IDX_W(IDX_W), .RCNT_W(RCNT_W)) u_sel (
    .head_i  (r_head),
    .valid_i (w_v),
    .comp_i  (w_c),
    .cnt_o   (w_nret)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      for (int d = 0; d < DEPTH; d++) r_rob[d] <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_fwd_valid <= '0;
      r_fwd_preg  <= '0;
      r_fwd_data  <= '0;
      r_ret_valid <= '0;
      r_ret_st    <= '0;
      r_ret_preg  <= '0;
      r_ret_free  <= '0;
      r_ret_data  <= '0;
    end else begin
      // Completion: tags that are not currently valid are dropped silently.
      for (int p = 0; p < CMPL_W; p++) begin
        r_fwd_valid[p] <= 1'b0;
        r_fwd_preg[p]  <= '0;
        r_fwd_data[p]  <= '0;
        if (cmpl_valid_i[p] && r_rob[cmpl_tag_i[p]].v) begin
          r_rob[cmpl_tag_i[p]].comp <= 1'b1;
          r_rob[cmpl_tag_i[p]].data <= cmpl_data_i[p];
          r_fwd_valid[p]            <= 1'b1;
          r_fwd_preg[p]             <= r_rob[cmpl_tag_i[p]].preg;
          r_fwd_data[p]             <= cmpl_data_i[p];
        end
      end
      if (w_ready) begin
        for (int s = 0; s < DISP_W; s++) begin
          if (disp_valid_i[s]) begin
            r_rob[w_disp_tag[s]] <= '{v: 1'b1, comp: 1'b0, is_store: disp_is_store_i[s],
                                      preg: disp_preg_i[s], old_preg: disp_old_preg_i[s],
                                      data: '0};
          end
        end
      end
      // Retire after completion so clearing a retiring slot takes precedence.
      for (int k = 0; k < RET_W; k++) begin
        r_ret_valid[k] <= 1'b0;
        r_ret_st[k]    <= 1'b0;
        r_ret_preg[k]  <= '0;
        r_ret_free[k]  <= '0;
        r_ret_data[k]  <= '0;
        if (k < int'(w_nret)) begin
          r_ret_valid[k]              <= 1'b1;
          r_ret_st[k]                 <= r_rob[w_ret_idx[k]].is_store;
          r_ret_preg[k]               <= r_rob[w_ret_idx[k]].preg;
          r_ret_free[k]               <= r_rob[w_ret_idx[k]].old_preg;
          r_ret_data[k]               <= r_rob[w_ret_idx[k]].data;
          r_rob[w_ret_idx[k]].v       <= 1'b0;
          r_rob[w_ret_idx[k]].comp    <= 1'b0;
        end
      end
      r_head  <= r_head + IDX_W'(w_nret);
      r_tail  <= r_tail + w_nalloc_eff[IDX_W-1:0];
      r_count <= r_count + w_nalloc_eff - (IDX_W+1)'(w_nret);
    end
  end

  assign disp_ready_o    = w_ready;
  assign disp_tag_o      = w_disp_tag;
  assign fwd_valid_o     = r_fwd_valid;
  assign fwd_preg_o      = r_fwd_preg;
  assign fwd_data_o      = r_fwd_data;
  assign ret_valid_o     = r_ret_valid;
  assign ret_is_store_o  = r_ret_st;
  assign ret_preg_o      = r_ret_preg;
  assign ret_free_preg_o = r_ret_free;
  assign ret_data_o      = r_ret_data;
  assign count_o         = r_count;
  assign empty_o         = (r_count == '0);
  assign full_o          = (r_count == (IDX_W+1)'(DEPTH));

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: stimulus pushes expected forwards and
// retirements into queues; a negedge monitor pops and compares every strobe.
module tb_reorder_buffer;

  logic             clk = 1'b0;
  logic             rst_n, flush;
  logic [1:0]       disp_valid, disp_st;
  logic [1:0][5:0]  disp_preg, disp_old;
  logic             disp_ready;
  logic [1:0][3:0]  disp_tag;
  logic [2:0]       cmpl_valid;
  logic [2:0][3:0]  cmpl_tag;
  logic [2:0][31:0] cmpl_data;
  logic [2:0]       fwd_valid;
  logic [2:0][5:0]  fwd_preg;
  logic [2:0][31:0] fwd_data;
  logic [1:0]       ret_valid, ret_st;
  logic [1:0][5:0]  ret_preg, ret_free;
  logic [1:0][31:0] ret_data;
  logic [4:0]       count;
  logic             empty, full;

  reorder_buffer dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .disp_valid_i(disp_valid), .disp_is_store_i(disp_st),
    .disp_preg_i(disp_preg), .disp_old_preg_i(disp_old),
    .disp_ready_o(disp_ready), .disp_tag_o(disp_tag),
    .cmpl_valid_i(cmpl_valid), .cmpl_tag_i(cmpl_tag), .cmpl_data_i(cmpl_data),
    .fwd_valid_o(fwd_valid), .fwd_preg_o(fwd_preg), .fwd_data_o(fwd_data),
    .ret_valid_o(ret_valid), .ret_is_store_o(ret_st), .ret_preg_o(ret_preg),
    .ret_free_preg_o(ret_free), .ret_data_o(ret_data),
    .count_o(count), .empty_o(empty), .full_o(full)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] preg; logic [31:0] data; } fwd_t;
  typedef struct { logic [5:0] preg; logic [5:0] free; logic [31:0] data; logic st; } ret_t;

  fwd_t fwd_q[$];
  ret_t ret_q[$];
  fwd_t fe;
  ret_t re;

  int checks = 0, failures = 0;
  int m_tail = 0, pn = 10;
  logic [5:0]  m_preg [16];
  logic [5:0]  m_old  [16];
  logic        m_st   [16];
  logic [31:0] m_data [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Dispatch the slots in vm; ok=1 means the ROB is expected to accept them.
  task automatic dispatch(input logic [1:0] vm, input bit ok);
    int k;
    logic [3:0] tg;
    k = 0;
    for (int s = 0; s < 2; s++) begin
      disp_valid[s] = vm[s];
      disp_preg[s]  = 6'(pn);
      disp_old[s]   = 6'(pn + 32);
      disp_st[s]    = (pn % 5 == 0);
      if (vm[s]) pn++;
    end
    #1;
    for (int s = 0; s < 2; s++) begin
      if (vm[s]) begin
        if (ok) begin
          tg = 4'(m_tail + k);
          chk("disp_tag", 64'(disp_tag[s]), 64'(tg));
          m_preg[tg] = disp_preg[s];
          m_old[tg]  = disp_old[s];
          m_st[tg]   = disp_st[s];
        end
        k++;
      end
    end
    tick();
    disp_valid = '0;
    if (ok) m_tail = (m_tail + k) % 16;
  endtask

  // Drive one completion port; push=1 when the tag is live and a forward is due.
  task automatic cpl(input int p, input int tag, input logic [31:0] d, input bit push);
    fwd_t f;
    cmpl_valid[p] = 1'b1;
    cmpl_tag[p]   = 4'(tag);
    cmpl_data[p]  = d;
    if (push) begin
      m_data[tag] = d;
      f.preg = m_preg[tag];
      f.data = d;
      fwd_q.push_back(f);
    end
  endtask

  task automatic exp_ret(input int tag);
    ret_t r;
    r.preg = m_preg[tag]; r.free = m_old[tag]; r.data = m_data[tag]; r.st = m_st[tag];
    ret_q.push_back(r);
  endtask

  task automatic clr_cmpl();
    cmpl_valid = '0; cmpl_tag = '0; cmpl_data = '0;
  endtask

  // Monitor: every strobe must match the head of its queue.
  always @(negedge clk) begin
    for (int p = 0; p < 3; p++) begin
      if (fwd_valid[p]) begin
        if (fwd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL fwd_unexpected port=%0d actual_preg=%0d expected=none", p, fwd_preg[p]);
        end else begin
          fe = fwd_q.pop_front();
          chk("fwd_preg", 64'(fwd_preg[p]), 64'(fe.preg));
          chk("fwd_data", 64'(fwd_data[p]), 64'(fe.data));
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (ret_valid[k]) begin
        if (ret_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ret_unexpected lane=%0d actual_preg=%0d expected=none", k, ret_preg[k]);
        end else begin
          re = ret_q.pop_front();
          chk("ret_preg",  64'(ret_preg[k]), 64'(re.preg));
          chk("ret_free",  64'(ret_free[k]), 64'(re.free));
          chk("ret_data",  64'(ret_data[k]), 64'(re.data));
          chk("ret_store", 64'(ret_st[k]),   64'(re.st));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    disp_valid = '0; disp_st = '0; disp_preg = '0; disp_old = '0;
    clr_cmpl();
    repeat (3) tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full",  64'(full),  64'd0);
    chk("rst_ready", 64'(disp_ready), 64'd1);
    chk("rst_retv",  64'(ret_valid), 64'd0);
    chk("rst_fwdv",  64'(fwd_valid), 64'd0);
    chk("rst_retd",  64'(ret_data),  64'd0);
    rst_n = 1'b1;
    tick();

    // Two allocations: tags 0,1 with pregs 10,11.
    dispatch(2'b11, 1);
    chk("d2_count", 64'(count), 64'd2);
    chk("d2_ready", 64'(disp_ready), 64'd1);
    chk("d2_preg1", 64'(m_preg[1]), 64'd11);

    // Younger completes first; nothing may retire until tag 0 completes.
    cpl(0, 1, 32'h55, 1); tick(); clr_cmpl();
    tick(); tick();
    chk("no_early_ret", 64'(ret_valid), 64'd0);
    cpl(1, 0, 32'hAA, 1); exp_ret(0); exp_ret(1);
    tick(); clr_cmpl();
    tick();
    chk("pair_retv", 64'(ret_valid), 64'd3);
    chk("pair_free0", 64'(ret_free[0]), 64'd42);
    chk("pair_count", 64'(count), 64'd0);
    chk("pair_empty", 64'(empty), 64'd1);

    // Tail walk to 5, then a slot-1-only dispatch takes tag 5.
    dispatch(2'b11, 1);
    dispatch(2'b01, 1);
    dispatch(2'b10, 1);
    dispatch(2'b11, 1);
    chk("t6_count", 64'(count), 64'd6);

    // Fill to 16.
    repeat (5) dispatch(2'b11, 1);
    chk("full_full",  64'(full), 64'd1);
    chk("full_ready", 64'(disp_ready), 64'd0);
    chk("full_count", 64'(count), 64'd16);
    dispatch(2'b11, 0);
    chk("full_hold", 64'(count), 64'd16);

    // Drain 2..14 in order, then 15 and 0 retire together across the wrap.
    for (int t = 2; t <= 14; t += 3) begin
      for (int p = 0; p < 3; p++) begin
        if (t + p <= 14) begin
          cpl(p, t + p, 32'h1000 + 32'(t + p), 1);
          exp_ret(t + p);
        end
      end
      tick(); clr_cmpl();
    end
    repeat (10) tick();
    chk("drain_count", 64'(count), 64'd3);
    cpl(0, 15, 32'hF0F0, 1); cpl(1, 0, 32'h0F0F, 1);
    exp_ret(15); exp_ret(0);
    tick(); clr_cmpl();
    tick();
    chk("wrap_retv",  64'(ret_valid), 64'd3);
    chk("wrap_lane0", 64'(ret_preg[0]), 64'(m_preg[15]));
    chk("wrap_lane1", 64'(ret_preg[1]), 64'(m_preg[0]));
    chk("wrap_count", 64'(count), 64'd1);

    // Completion to a retired tag is ignored.
    cpl(2, 5, 32'hDEAD, 0); tick(); clr_cmpl();
    chk("dead_fwd", 64'(fwd_valid), 64'd0);

    // Flush with three completions and a dispatch pending.
    dispatch(2'b11, 1);
    chk("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1;
    cpl(0, 1, 32'h1, 0); cpl(1, 2, 32'h2, 0); cpl(2, 3, 32'h3, 0);
    disp_valid = 2'b11;
    tick();
    flush = 1'b0; disp_valid = '0; clr_cmpl();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_fwd",   64'(fwd_valid), 64'd0);
    chk("flush_ret",   64'(ret_valid), 64'd0);
    tick();
    chk("flush_ret2",  64'(ret_valid), 64'd0);
    m_tail = 0;
    dispatch(2'b11, 1);

    // Reset mid-flight with a completion on the same edge.
    cpl(0, 0, 32'hBEEF, 0);
    rst_n = 1'b0;
    tick(); clr_cmpl();
    tick();
    chk("mrst_count", 64'(count), 64'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mrst_ret", 64'(ret_valid), 64'd0);

    chk("fwd_q_drained", 64'(fwd_q.size()), 64'd0);
    chk("ret_q_drained", 64'(ret_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
